// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer front end.
package bit_serializer_pkg;

   typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t;

   // Bit-counter width; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load handshake and serial output bundle between an upstream source and the serializer.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             out;
   logic             out_valid;
   logic             last;
   logic             busy;

   modport master (
      output data_in, load_valid,
      input  load_ready, out, out_valid, last, busy
   );

   modport slave (
      input  data_in, load_valid,
      output load_ready, out, out_valid, last, busy
   );

endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer; lets the next word wait while the shifter is busy.
module ser_hold_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] hold_data,
   output logic             hold_full
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d;

   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (pop) begin
         full_d = 1'b0;
      end
      if (push) begin
         data_d = data_in;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign hold_data = data_q;
   assign hold_full = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one bit per clock, gapless across words via a one-entry buffer.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic             clk,
   input logic             reset,
   bit_serializer_if.slave bus
);

   localparam int unsigned    CntW    = cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   ser_state_t        state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;

   logic [WIDTH-1:0]  hold_data;
   logic              hold_full;
   logic              accept;
   logic              at_last;
   logic              direct_load;
   logic              push;
   logic              pop;
   logic              out_bit;
   logic [WIDTH-1:0]  shifted;

   assign bus.load_ready = !hold_full && !reset;
   assign accept         = bus.load_valid && bus.load_ready;
   assign at_last        = (state_q == SHIFT) && (bit_cnt_q == LastCnt);

   // A word bypasses the buffer when the shifter is free now or frees on this edge.
   assign direct_load = accept && ((state_q == IDLE) || (at_last && !hold_full));
   assign push        = accept && !direct_load;
   assign pop         = at_last && hold_full;

   assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d   = bus.data_in;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (!at_last) begin
               shreg_d   = shifted;
               bit_cnt_d = bit_cnt_q + CntW'(1);
            end else if (hold_full) begin
               shreg_d   = hold_data;
               bit_cnt_d = '0;
            end else if (accept) begin
               shreg_d   = bus.data_in;
               bit_cnt_d = '0;
            end else begin
               shreg_d   = shifted;
               bit_cnt_d = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   ser_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .data_in   (bus.data_in),
      .hold_data (hold_data),
      .hold_full (hold_full)
   );

   assign bus.out_valid = (state_q == SHIFT);
   assign bus.out       = bus.out_valid && out_bit;
   assign bus.last      = at_last;
   assign bus.busy      = bus.out_valid || hold_full;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the Mealy non-overlapping sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single-bit serial output, which connects directly to the detector's `in` port. A one-entry holding buffer allows back-to-back words to stream without gap cycles.

## Interface
- `WIDTH`, 8: word width in bits; legal range WIDTH >= 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `data_in`  in  WIDTH: word to serialize; sampled on an accepted handshake.
- `load_valid`  in  1: `data_in` is valid.
- `load_ready`  out  1: block can accept a word this cycle.
- `out`  out  1: serial bit; feeds the detector's `in`.
- `out_valid`  out  1: `out` carries a real data bit.
- `last`  out  1: current `out` bit is the final bit of its word.
- `busy`  out  1: a word is being shifted or is held.

## Operation
- Datapath: shift register `shreg[WIDTH]`, bit counter `bit_cnt` ($clog2(WIDTH) bits), holding buffer `hold_data[WIDTH]` with `hold_full` flag.
- FSM states: IDLE (shifter empty) and SHIFT (shifter emitting bits).
- Accept = `load_valid && load_ready`. `load_ready = !hold_full && !reset`.
- Accept in IDLE: word loads directly into the shifter; `bit_cnt` = 0; go to SHIFT.
- Accept in SHIFT, `bit_cnt == WIDTH-1`, hold empty: word loads directly into the shifter (gapless); stay in SHIFT.
- Accept in SHIFT otherwise: word goes to `hold_data`; `hold_full` = 1.
- SHIFT, `bit_cnt < WIDTH-1`: shift one position toward the output end; `bit_cnt`++.
- SHIFT, `bit_cnt == WIDTH-1`:
  - Hold full: move hold into the shifter; `hold_full` = 0; `bit_cnt` = 0.
  - Else, accept this cycle: load the new word into the shifter as above.
  - Else: go to IDLE.
- Hold moving to the shifter and a new accept on the same edge cannot occur, because `load_ready` is low while `hold_full`.
- `out` = output end of `shreg` (MSB or LSB per `MSB_FIRST`) when in SHIFT; `out` = 0 in IDLE.
- `out_valid` = (state == SHIFT). `last` = SHIFT && `bit_cnt == WIDTH-1`.
- `busy` = `out_valid || hold_full`.
- `data_in` is ignored when there is no accept.
- When idle, `out` is 0. The downstream detector sees idle as a zero bit, so gaps can break sequences that span word boundaries. Upstream logic keeps words back-to-back when that matters.

## Timing
- Reset asserted: immediately (asynchronously) state = IDLE, `hold_full` = 0, `bit_cnt` = 0, `shreg` = 0, `hold_data` = 0.
- Output values during reset: `out` = 0, `out_valid` = 0, `last` = 0, `busy` = 0, `load_ready` = 0.
- Reset mid-word: the in-flight word and the held word are discarded; no partial output after reset deasserts.
- After reset deasserts, `load_ready` = 1.
- Latency: word accepted at edge N, first bit on `out` during cycle N+1; last bit during cycle N+WIDTH with `last` = 1.
- Throughput: one bit per clock. Continuous `load_valid` gives 100% `out_valid` with no bubble between words.
- `load_ready` falls in the cycle after the hold buffer fills. It rises in the cycle after the hold contents transfer into the shifter.
- All outputs are registered or decoded from registers only. There is no combinational path from `load_valid` or `data_in` to `out`, `out_valid` or `last`.

## Structure
- Shared package `bit_serializer_pkg` contains:
  - state enum `ser_state_t` {IDLE, SHIFT};
  - function `cnt_width(WIDTH)` returning $clog2(WIDTH).
- One sub-module `ser_hold_buf`: a one-entry valid/ready buffer holding `hold_data` and `hold_full`, with inputs push and pop.
- The top level contains the FSM, the shifter, the counter and the output decode.

## Test plan
- Reset: assert `reset` mid-simulation with a word half-shifted.
  - Required: `out`, `out_valid`, `last`, `busy` = 0 at once, with no clock edge needed.
  - Required: after deassert, `load_ready` = 1 and no further valid bits appear.
- Single word, WIDTH = 8, MSB_FIRST = 1: accept 8'b1101_0000 at edge N.
  - Required: `out` = 1,1,0,1,0,0,0,0 in cycles N+1..N+8; `last` high only in cycle N+8; IDLE in cycle N+9.
- Back-to-back: hold `load_valid` high with words 8'hB6 then 8'h3C.
  - Required: 16 consecutive `out_valid` cycles, bits 10110110 00111100.
  - Required: `load_ready` low while the second word is held.
- Backpressure: present three words with `load_valid` held high.
  - Required: the third word is not accepted until the first word's last bit is sent; no word is lost or duplicated; 24 bits in order.
- LSB first, MSB_FIRST = 0: accept 8'b0000_1011.
  - Required: `out` = 1,1,0,1,0,0,0,0.
- End-to-end with the detector connected: send a word containing the target sequence twice in non-overlapping positions.
  - Required: the detector `out` pulses exactly twice, each in the cycle its final bit is presented.
